// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer.
// Fetches at pc_out over req/gnt/rvalid, then hands the word to decode.
module pc_fetch #(
  parameter logic [31:2] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] npc_in,
  output logic [31:2] pc_out,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:2] inst_pc,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    VALID
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:2] pc_q;
  logic [31:0] inst_q;
  logic [31:0] count_q;
  logic        xfer;
  logic        capture;

  assign xfer    = (state_q == VALID) && inst_ready;
  assign capture = (state_q == WAIT) && imem_rvalid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:  state_d = REQ;
      REQ:   if (imem_gnt) state_d = WAIT;
      WAIT:  if (imem_rvalid) state_d = VALID;
      VALID: if (inst_ready) state_d = REQ;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) inst_q <= imem_rdata;
      if (xfer) begin
        pc_q    <= npc_in;
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Handshake outputs come from the state register alone.
  assign imem_req   = (state_q == REQ);
  assign inst_valid = (state_q == VALID);
  assign pc_out     = pc_q;
  assign imem_addr  = pc_q;
  assign inst_pc    = pc_q;
  assign inst_out   = inst_q;
  assign inst_count = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized self-checking bench for pc_fetch.
// Transaction-level model tracks expected PC and consumed count.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:2] npc_in = '0;
  logic [31:2] pc_out;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:2] inst_pc;
  logic [31:0] inst_count;

  int unsigned pass_cnt = 0;
  int unsigned total = 0;
  int unsigned cyc = 0;

  logic [29:0] exp_pc;
  logic [31:0] exp_cnt;

  pc_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .npc_in(npc_in),
    .pc_out(pc_out),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic hold_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    exp_pc = 30'h0C00;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One instruction with gw/rw/dw extra stall cycles per phase.
  task automatic run_txn(input int gw, input int rw, input int dw,
                         input logic [31:0] data,
                         input logic [29:0] npc);
    for (int i = 0; i <= gw; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0)
        $display("FAIL req_phase: req=%b addr=%h vld=%b want 1 %h 0",
                 imem_req, imem_addr, inst_valid, exp_pc);
      else pass_cnt++;
      imem_gnt = (i == gw);
      imem_rvalid = $urandom_range(0, 1);
      imem_rdata = $urandom;
      @(negedge clk);
    end
    imem_gnt = 1'b0;
    for (int i = 0; i <= rw; i++) begin
      total++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc_out !== exp_pc)
        $display("FAIL wait_phase: req=%b vld=%b pc=%h want 0 0 %h",
                 imem_req, inst_valid, pc_out, exp_pc);
      else pass_cnt++;
      imem_rvalid = (i == rw);
      imem_rdata = (i == rw) ? data : $urandom;
      @(negedge clk);
    end
    for (int i = 0; i <= dw; i++) begin
      total++;
      if (inst_valid !== 1'b1 || inst_out !== data ||
          inst_pc !== exp_pc || pc_out !== exp_pc || imem_req !== 1'b0)
        $display("FAIL valid_phase: vld=%b inst=%h ipc=%h pc=%h want 1 %h %h",
                 inst_valid, inst_out, inst_pc, pc_out, data, exp_pc);
      else pass_cnt++;
      imem_rvalid = $urandom_range(0, 1);
      imem_rdata = $urandom;
      inst_ready = (i == dw);
      npc_in = (i == dw) ? npc : 30'($urandom);
      @(negedge clk);
    end
    inst_ready = 1'b0;
    imem_rvalid = 1'b0;
    exp_pc = npc;
    exp_cnt = exp_cnt + 1;
    total++;
    if (inst_count !== exp_cnt || inst_valid !== 1'b0)
      $display("FAIL count: cnt=%h vld=%b want %h 0",
               inst_count, inst_valid, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    hold_reset();
    total++;
    if (pc_out !== 30'h0C00 || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        inst_out !== 32'h0 || inst_count !== 32'h0 || inst_pc !== 30'h0C00)
      $display("FAIL reset_vals: pc=%h req=%b vld=%b inst=%h cnt=%h",
               pc_out, imem_req, inst_valid, inst_out, inst_count);
    else pass_cnt++;
    release_reset();
    total++;
    if (imem_req !== 1'b0 || pc_out !== 30'h0C00)
      $display("FAIL boot_cycle: req=%b pc=%h want 0 0c00", imem_req, pc_out);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 30'h0C00 || inst_count !== 0)
      $display("FAIL first_req: req=%b addr=%h cnt=%h want 1 0c00 0",
               imem_req, imem_addr, inst_count);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int unsigned t0;
    t0 = cyc;
    run_txn(0, 0, 0, 32'h2008_0005, 30'h0C01);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 30'h0C01 || cyc - t0 != 3 ||
        inst_count !== 1)
      $display("FAIL b2b_next: req=%b addr=%h dt=%0d cnt=%0d want 1 0c01 3 1",
               imem_req, imem_addr, cyc - t0, inst_count);
    else pass_cnt++;
    run_txn(0, 0, 0, 32'h1234_5678, 30'h0C02);
  endtask

  task automatic test_stalls();
    int unsigned t0;
    t0 = cyc;
    run_txn(4, 3, 5, 32'hCAFE_F00D, 30'h0C03);
    total++;
    if (cyc - t0 != 15 || imem_addr !== 30'h0C03)
      $display("FAIL stall_len: dt=%0d addr=%h want 15 0c03",
               cyc - t0, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    run_txn(1, 0, 2, 32'h0800_0004, 30'h0000_0010);
    total++;
    if (imem_addr !== 30'h0000_0010 || imem_req !== 1'b1)
      $display("FAIL branch_addr: addr=%h req=%b want 0010 1",
               imem_addr, imem_req);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fetch();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    exp_pc = 30'h0C00;
    exp_cnt = 0;
    #1;
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc_out !== 30'h0C00 ||
        inst_count !== 0 || inst_out !== 0)
      $display("FAIL async_reset: req=%b vld=%b pc=%h cnt=%h inst=%h",
               imem_req, inst_valid, pc_out, inst_count, inst_out);
    else pass_cnt++;
    release_reset();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 ||
          imem_addr !== 30'h0C00 || inst_out !== 32'h0)
        $display("FAIL stale_rvalid: vld=%b req=%b addr=%h inst=%h",
                 inst_valid, imem_req, imem_addr, inst_out);
      else pass_cnt++;
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    run_txn(0, 1, 0, 32'h0000_0001, 30'h0C01);
  endtask

  task automatic test_counter_wrap();
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    exp_cnt = 32'hFFFF_FFFF;
    total++;
    if (inst_count !== 32'hFFFF_FFFF || imem_req !== 1'b1 ||
        imem_addr !== exp_pc)
      $display("FAIL wrap_pre: cnt=%h req=%b addr=%h", inst_count,
               imem_req, imem_addr);
    else pass_cnt++;
    run_txn(0, 0, 1, 32'h1111_2222, 30'h0C05);
    total++;
    if (inst_count !== 32'h0 || imem_addr !== 30'h0C05)
      $display("FAIL wrap_post: cnt=%h addr=%h want 0 0c05",
               inst_count, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_txn($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom, 30'($urandom));
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_stalls();
    test_branch();
    test_reset_mid_fetch();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
